// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states, divide latency.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  // Cycles of Busy for a divide at the default width: one per quotient bit plus the sign-fix cycle.
  localparam int DIV_LAT = DEFAULT_WIDTH + 1;

  function automatic int divLatency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Op/result bundle between the EX stage (master) and the multiply/divide unit (slave).
// Latency: n/a (wires only).
// Backpressure: the master must hold off Start while Busy is high; a Start during Busy is dropped.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, SrcA, SrcB, Flush,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, Flush,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mips_div_core.sv
// Restoring radix-2 divider datapath on unsigned magnitudes: one quotient bit per step.
// Latency: STEPS step cycles after load; lastStep flags the step that produces the final bit.
// Backpressure: none; the controlling FSM decides when to load and step.
module mips_div_core #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             lastStep
);
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [WIDTH-1:0] remQ;
  logic [WIDTH-1:0] quotQ;
  logic [WIDTH-1:0] divisorQ;
  logic [CNT_W-1:0] cntQ;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Dividend bits shift out of the quotient register MSB-first into the partial remainder.
  assign shifted   = {remQ, quotQ[WIDTH-1]};
  assign diff      = shifted - {1'b0, divisorQ};
  assign quotient  = quotQ;
  assign remainder = remQ;
  assign lastStep  = (cntQ == CNT_W'(STEPS - 1));

  // Partial remainder, quotient shift register and step counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      remQ     <= '0;
      quotQ    <= '0;
      divisorQ <= '0;
      cntQ     <= '0;
    end else if (load) begin
      remQ     <= '0;
      quotQ    <= dividend;
      divisorQ <= divisor;
      cntQ     <= '0;
    end else if (step) begin
      if (!diff[WIDTH]) begin
        remQ  <= diff[WIDTH-1:0];
        quotQ <= {quotQ[WIDTH-2:0], 1'b1};
      end else begin
        remQ  <= shifted[WIDTH-1:0];
        quotQ <= {quotQ[WIDTH-2:0], 1'b0};
      end
      cntQ <= cntQ + 1'b1;
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO; MADD/MSUB exist only when MULDIV_MADD_EN is defined.
// Latency: mult MUL_STAGES cycles, div WIDTH+1 cycles, MTHI/MTLO written at the accepting edge.
// Backpressure: Busy high while a mult/div is in flight; Start during Busy is ignored, Flush aborts.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input logic               CLK,
  input logic               RST,
  mips_muldiv_unit_if.slave bus
);
  localparam int MCNT_W    = $clog2(MUL_STAGES + 1);
  localparam int DIV_STEPS = divLatency(WIDTH) - 1;

  state_e              stateQ, stateNext;
  logic [MCNT_W-1:0]   mulCntQ;
  opcode_e             opIn, opQ;
  logic [WIDTH-1:0]    opAQ, opBQ, hiQ, loQ;
  logic                busyQ, doneQ;

  logic                startOk, accept, isMul, isDiv, isMove;
  logic                mulWrite, fixWrite, divLoad, divStep, divLast;
  logic                divSignedIn, mulSigned, divSignedQ, quotNeg, remNeg, divByZero;
  logic [WIDTH-1:0]    magA, magB, quot, rem, divHi, divLo;
  logic [2*WIDTH-1:0]  extA, extB, product, mulResult;

  assign opIn    = opcode_e'(bus.Op);
  assign startOk = bus.Start && !bus.Flush;

  // Classify the incoming op; MADD/MSUB fall into the default (ignored) class unless enabled.
  always_comb begin
    isMul  = 1'b0;
    isDiv  = 1'b0;
    isMove = 1'b0;
    case (opIn)
      OP_MULT, OP_MULTU: isMul = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB:  isMul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   isDiv = 1'b1;
      OP_MTHI, OP_MTLO:  isMove = 1'b1;
      default: ;
    endcase
  end

  // Next-state and per-cycle control; Flush beats completion so an aborted op never writes.
  always_comb begin
    stateNext = stateQ;
    mulWrite  = 1'b0;
    fixWrite  = 1'b0;
    divStep   = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (startOk && isMul)      stateNext = ST_MUL;
        else if (startOk && isDiv) stateNext = ST_DIV;
      end
      ST_MUL: begin
        if (bus.Flush) stateNext = ST_IDLE;
        else if (mulCntQ == '0) begin
          mulWrite  = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (bus.Flush) stateNext = ST_IDLE;
        else begin
          divStep = 1'b1;
          if (divLast) stateNext = ST_FIX;
        end
      end
      ST_FIX: begin
        if (bus.Flush) stateNext = ST_IDLE;
        else begin
          fixWrite  = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign accept  = (stateQ == ST_IDLE) && startOk;
  assign divLoad = accept && isDiv;

  // State register; Busy is registered from the next state so it tracks FSM != IDLE exactly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateQ <= ST_IDLE;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateNext;
      busyQ  <= (stateNext != ST_IDLE);
    end
  end

  // Multiply latency counter: loaded on accept, counts down to the write cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mulCntQ <= '0;
    end else if (accept && isMul) begin
      mulCntQ <= MCNT_W'(MUL_STAGES - 1);
    end else if (stateNext == ST_IDLE) begin
      mulCntQ <= '0;
    end else if (stateQ == ST_MUL) begin
      mulCntQ <= mulCntQ - 1'b1;
    end
  end

  // Capture the op and raw operands on accept; the sign fix-up and div-by-zero need them later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      opQ  <= OP_MULT;
      opAQ <= '0;
      opBQ <= '0;
    end else if (accept) begin
      opQ  <= opIn;
      opAQ <= bus.SrcA;
      opBQ <= bus.SrcB;
    end
  end

  // Multiply: sign- or zero-extend to 2*WIDTH so one wrap-around product covers both flavours.
  assign mulSigned = (opQ != OP_MULTU);
  assign extA      = mulSigned ? {{WIDTH{opAQ[WIDTH-1]}}, opAQ} : {{WIDTH{1'b0}}, opAQ};
  assign extB      = mulSigned ? {{WIDTH{opBQ[WIDTH-1]}}, opBQ} : {{WIDTH{1'b0}}, opBQ};
  assign product   = extA * extB;

`ifdef MULDIV_MADD_EN
  // Accumulate against HI/LO as they stand on the write edge.
  always_comb begin
    mulResult = product;
    case (opQ)
      OP_MADD: mulResult = {hiQ, loQ} + product;
      OP_MSUB: mulResult = {hiQ, loQ} - product;
      default: mulResult = product;
    endcase
  end
`else
  assign mulResult = product;
`endif

  // Divide: the core works on magnitudes; signs are reapplied in FIX from the captured operands.
  assign divSignedIn = (opIn == OP_DIV);
  assign magA = (divSignedIn && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
  assign magB = (divSignedIn && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

  mips_div_core #(
    .WIDTH (WIDTH),
    .STEPS (DIV_STEPS)
  ) u_divCore (
    .CLK       (CLK),
    .RST       (RST),
    .load      (divLoad),
    .step      (divStep),
    .dividend  (magA),
    .divisor   (magB),
    .quotient  (quot),
    .remainder (rem),
    .lastStep  (divLast)
  );

  // Signed min / -1 needs no special case: the magnitude quotient negates back to min.
  assign divSignedQ = (opQ == OP_DIV);
  assign quotNeg    = divSignedQ && (opAQ[WIDTH-1] ^ opBQ[WIDTH-1]);
  assign remNeg     = divSignedQ && opAQ[WIDTH-1];
  assign divByZero  = (opBQ == '0);
  assign divLo      = divByZero ? '1   : (quotNeg ? -quot : quot);
  assign divHi      = divByZero ? opAQ : (remNeg  ? -rem  : rem);

  // HI/LO writes from mult/div completion or MTHI/MTLO, plus the one-cycle Done pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hiQ   <= '0;
      loQ   <= '0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= mulWrite || fixWrite;
      if (mulWrite) begin
        {hiQ, loQ} <= mulResult;
      end else if (fixWrite) begin
        hiQ <= divHi;
        loQ <= divLo;
      end else if (accept && isMove) begin
        if (opIn == OP_MTHI) hiQ <= bus.SrcA;
        else                 loQ <= bus.SrcA;
      end
    end
  end

  assign bus.Busy = busyQ;
  assign bus.Done = doneQ;
  assign bus.HI   = hiQ;
  assign bus.LO   = loQ;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: directed ops, literal result checks and a per-cycle reference model.
// Latency: WIDTH=32, MUL_STAGES=3 (mult busy 3 cycles, div busy 33 cycles).
// Backpressure: stimulus waits for Busy to drop, with a cycle bound, before the next op.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  localparam int W  = 32;
  localparam int MS = 3;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mips_muldiv_unit_if #(.WIDTH(W)) bus();

  mips_muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an op in flight is just a result plus a count of busy cycles left.
  logic [W-1:0] mHI, mLO;
  logic         mBusy, mDone;
  int           mLeft;
  int           mKind;   // 0 plain write, 1 add product, 2 subtract product
  logic [63:0]  mRes;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mHI = '0; mLO = '0; mLeft = 0; mDone = 1'b0; mBusy = 1'b0; mKind = 0; mRes = '0;
    end else begin
      mDone = 1'b0;
      if (mLeft > 0) begin
        if (bus.Flush) mLeft = 0;
        else begin
          mLeft--;
          if (mLeft == 0) begin
            if (mKind == 1)      {mHI, mLO} = {mHI, mLO} + mRes;
            else if (mKind == 2) {mHI, mLO} = {mHI, mLO} - mRes;
            else                 {mHI, mLO} = mRes;
            mDone = 1'b1;
          end
        end
      end else if (bus.Start && !bus.Flush) begin
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(bus.SrcA));
        sb = longint'($signed(bus.SrcB));
        ua = {32'b0, bus.SrcA};
        ub = {32'b0, bus.SrcB};
        mKind = 0;
        case (bus.Op)
          3'd0: begin mRes = sa * sb; mLeft = MS; end
          3'd1: begin mRes = ua * ub; mLeft = MS; end
          3'd2, 3'd3: begin
            if (bus.SrcB == '0) mRes = {bus.SrcA, 32'hFFFFFFFF};
            else if (bus.Op == 3'd2) begin
              q = sa / sb; r = sa % sb;
              mRes = {r[31:0], q[31:0]};
            end else begin
              q = longint'(ua / ub); r = longint'(ua % ub);
              mRes = {r[31:0], q[31:0]};
            end
            mLeft = DIV_LAT;
          end
          3'd4: mHI = bus.SrcA;
          3'd5: mLO = bus.SrcA;
`ifdef MULDIV_MADD_EN
          3'd6: begin mRes = sa * sb; mKind = 1; mLeft = MS; end
          3'd7: begin mRes = sa * sb; mKind = 2; mLeft = MS; end
`endif
          default: ;
        endcase
      end
      mBusy = (mLeft > 0);
    end
  end

  // Every cycle out of reset, all four outputs must match the model.
  always @(negedge CLK) begin
    if (RST) begin
      check("cyc_busy", bus.Busy, mBusy);
      check("cyc_done", bus.Done, mDone);
      check("cyc_hi",   bus.HI,   mHI);
      check("cyc_lo",   bus.LO,   mLO);
    end
  end

  // Issue one op for one cycle, then count Busy cycles (bounded).
  task automatic doOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int n);
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge CLK);
    bus.Start = 1'b0;
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic expectRes(input string name, input int n, input int expN,
                           input logic [W-1:0] hi, input logic [W-1:0] lo);
    check({name, "_lat"},  n, expN);
    check({name, "_done"}, bus.Done, 1'b1);
    check({name, "_hi"},   bus.HI, hi);
    check({name, "_lo"},   bus.LO, lo);
  endtask

  int n;

  initial begin
    bus.Start = 1'b0; bus.Op = 3'd0; bus.SrcA = '0; bus.SrcB = '0; bus.Flush = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_hi",   bus.HI,   64'h0);
    check("rst_lo",   bus.LO,   64'h0);
    check("rst_busy", bus.Busy, 64'h0);
    check("rst_done", bus.Done, 64'h0);
    RST = 1'b1;

    doOp(3'd0, 32'hFFFFFFFF, 32'h00000002, n);
    expectRes("mult", n, 3, 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge CLK);
    check("mult_done_pulse", bus.Done, 64'h0);

    doOp(3'd1, 32'hFFFFFFFF, 32'h00000002, n);
    expectRes("multu", n, 3, 32'h00000001, 32'hFFFFFFFE);

    doOp(3'd2, 32'hFFFFFFF9, 32'h00000002, n);
    expectRes("div_neg", n, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);

    doOp(3'd3, 32'h00000007, 32'h00000000, n);
    expectRes("divu_zero", n, 33, 32'h00000007, 32'hFFFFFFFF);

    doOp(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    expectRes("div_ovf", n, 33, 32'h00000000, 32'h80000000);

    doOp(3'd2, 32'd100, 32'hFFFFFFF9, n);
    expectRes("div_mix", n, 33, 32'h00000002, 32'hFFFFFFF2);

    doOp(3'd2, 32'hFFFFFFF8, 32'h00000000, n);
    expectRes("div_sz", n, 33, 32'hFFFFFFF8, 32'hFFFFFFFF);

    // Flush in the 10th busy cycle of a divide; a MULT offered mid-divide is dropped.
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'd2; bus.SrcA = 32'd50; bus.SrcB = 32'd3;
    @(negedge CLK);                      // busy cycle 1
    bus.Start = 1'b0;
    repeat (3) @(negedge CLK);           // busy cycle 4
    bus.Start = 1'b1; bus.Op = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd3;
    @(negedge CLK);                      // busy cycle 5
    bus.Start = 1'b0;
    repeat (5) @(negedge CLK);           // busy cycle 10
    check("flush_pre_busy", bus.Busy, 64'h1);
    bus.Flush = 1'b1;
    @(negedge CLK);
    bus.Flush = 1'b0;
    check("flush_busy", bus.Busy, 64'h0);
    check("flush_done", bus.Done, 64'h0);
    check("flush_hi",   bus.HI,   32'hFFFFFFF8);
    check("flush_lo",   bus.LO,   32'hFFFFFFFF);
    @(negedge CLK);
    check("ignored_busy", bus.Busy, 64'h0);

    doOp(3'd4, 32'h12345678, 32'h0, n);
    check("mthi_lat",  n, 0);
    check("mthi_hi",   bus.HI,   32'h12345678);
    check("mthi_done", bus.Done, 64'h0);
    doOp(3'd5, 32'h9ABCDEF0, 32'h0, n);
    check("mtlo_lat", n, 0);
    check("mtlo_lo",  bus.LO, 32'h9ABCDEF0);
    check("mtlo_hi",  bus.HI, 32'h12345678);

    // Start held through completion: the completion edge must not accept.
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'd1; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
    repeat (8) @(negedge CLK);
    bus.Start = 1'b0;
    n = 0;
    while (bus.Busy && n < 200) begin n++; @(negedge CLK); end
    check("b2b_idle", bus.Busy, 64'h0);
    check("b2b_hi",   bus.HI,   32'h0);
    check("b2b_lo",   bus.LO,   32'h6);

    doOp(3'd4, 32'h0, 32'h0, n);
    doOp(3'd5, 32'h5, 32'h0, n);
    doOp(3'd6, 32'd3, 32'd4, n);
`ifdef MULDIV_MADD_EN
    expectRes("madd", n, 3, 32'h0, 32'd17);
    doOp(3'd7, 32'd2, 32'd3, n);
    expectRes("msub", n, 3, 32'h0, 32'd11);
`else
    check("madd_off_lat", n, 0);
    check("madd_off_hi",  bus.HI, 32'h0);
    check("madd_off_lo",  bus.LO, 32'h5);
    doOp(3'd7, 32'd2, 32'd3, n);
    check("msub_off_lat", n, 0);
    check("msub_off_lo",  bus.LO, 32'h5);
`endif

    // Asynchronous reset in the middle of a multiply.
    @(negedge CLK);
    bus.Start = 1'b1; bus.Op = 3'd0; bus.SrcA = 32'd5; bus.SrcB = 32'd5;
    @(negedge CLK);
    bus.Start = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("arst_hi",   bus.HI,   64'h0);
    check("arst_lo",   bus.LO,   64'h0);
    check("arst_busy", bus.Busy, 64'h0);
    check("arst_done", bus.Done, 64'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_lo", bus.LO, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS CPU.
- Sits beside the EX stage: accepts an op from EX and runs multi-cycle, while the hazard logic stalls MFHI/MFLO and new muldiv ops on Busy.
- Multiply latency is configurable through pipeline depth; divide is iterative, radix-2, one quotient bit per cycle.
- Supports flush on branch/exception redirect.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_STAGES, 3, multiply latency in cycles from the accepting edge to the HI/LO write; legal values are 1 or more.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  op valid this cycle.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- SrcA  input  WIDTH  rs operand: multiplicand or dividend; data for MTHI/MTLO.
- SrcB  input  WIDTH  rt operand: multiplier or divisor.
- Flush  input  1  abort the in-flight op and discard a same-cycle Start.
- Busy  output  1  multi-cycle op in flight.
- Done  output  1  one-cycle pulse after the HI/LO write by a mult/div.
- HI  output  WIDTH  HI register; remainder or upper product.
- LO  output  WIDTH  LO register; quotient or lower product.

Behaviour:
- Reset: while RST=0, HI=0, LO=0, Busy=0, Done=0, FSM=IDLE, counters=0. Reset is asynchronous, so a reset mid-operation aborts immediately.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept condition: Start=1, Flush=0, FSM=IDLE. Start while Busy=1 is ignored; the CPU must stall instead.
- Timing notation: edge 0 is the accepting edge.
- MULT/MULTU:
  - IDLE->MUL at edge 0.
  - Product is 2*WIDTH bits, signed or unsigned per Op.
  - HI/LO are written at edge MUL_STAGES, then MUL->IDLE.
  - Busy=1 for exactly MUL_STAGES cycles. Done=1 for the one cycle after the write.
- DIV/DIVU:
  - IDLE->DIV at edge 0. Operands are converted to magnitudes when signed.
  - WIDTH iteration edges, then DIV->FIX.
  - FIX applies signs: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - HI=remainder and LO=quotient are written at edge WIDTH+1, then FIX->IDLE.
  - Busy=1 for WIDTH+1 cycles. Done pulses as for multiply.
- Division by zero is defined: HI=SrcA, LO=all ones. It still takes the full latency.
- Signed overflow is defined: DIV with SrcA = minimum negative value and SrcB = -1 gives LO = minimum negative value, HI = 0.
- MTHI/MTLO:
  - Write HI or LO with SrcA at edge 0 when accepted.
  - Busy is not asserted and Done stays 0.
- Unaccepted ops leave HI/LO unchanged.
- Flush:
  - In MUL, DIV or FIX: return to IDLE at the next edge. HI/LO keep their old values, Busy=0, Done=0.
  - Flush takes priority over a completion on the same edge, so no write happens.
- Completion-edge Start: an op cannot be accepted on the edge where Busy is still 1. The next op is accepted earliest one cycle later.
- HI and LO are driven directly from registers; there is no combinational path from the inputs.
- Busy is registered and equals (FSM != IDLE).

Optional Feature:
- Macro: MULDIV_MADD_EN.
- When defined:
  - Op 6 MADD computes {HI,LO} + signed SrcA*SrcB.
  - Op 7 MSUB computes {HI,LO} - signed SrcA*SrcB.
  - Both use the MUL path, the same latency, and 2*WIDTH wrap-around arithmetic.
  - The accumulate uses the HI/LO values present at the write edge.
- When not defined: Ops 6 and 7 are ignored. They are not accepted, Busy stays 0, and HI/LO are unchanged.

Decomposition:
- Shared package mips_pkg holds:
  - the Op encodings;
  - the FSM state enum;
  - the DIV_LAT constant (WIDTH+1).
- Sub-module mips_div_core contains the restoring divide iteration datapath: partial remainder register, quotient shift register and bit counter. The FSM, sign handling and HI/LO registers stay in the top.

Test Plan (WIDTH=32, MUL_STAGES=3):
- MULT 0xFFFFFFFF * 0x00000002 -> at edge 3, HI=0xFFFFFFFF and LO=0xFFFFFFFE; Busy high 3 cycles; Done high 1 cycle.
- MULTU 0xFFFFFFFF * 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> at edge 33, LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU 7/0 -> HI=0x00000007, LO=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- Start DIV; Flush in the 10th Busy cycle -> Busy=0 next edge, HI/LO unchanged, no Done. A MULT Start while Busy -> ignored.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> HI/LO updated next edge, Busy=0. RST low mid-MUL -> HI=LO=0, Busy=0 immediately.
- With MULDIV_MADD_EN, HI:LO=0:5, MADD 3*4 -> LO=17. Without the macro, the same stimulus -> HI:LO remain 0:5.
